// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the P7 inter-stage registers: exception codes, fixed PCs,
// payload packing offsets, and the per-cycle stage action.
package pipe_stage_reg_pkg;

  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  localparam logic [31:0] HANDLER_PC   = 32'h0000_4180;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

  // Payload layout: inst | ALU | rt | MDU | ext32, LSB first
  localparam int unsigned PL_INST_LSB = 0;
  localparam int unsigned PL_ALU_LSB  = 32;
  localparam int unsigned PL_RT_LSB   = 64;
  localparam int unsigned PL_MDU_LSB  = 96;
  localparam int unsigned PL_EXT_LSB  = 128;
  localparam int unsigned PL_W        = 160;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_LOAD,
    ACT_BUBBLE,
    ACT_REDIRECT
  } stage_act_e;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle between a feeding stage and its pipeline register.
interface pipe_stage_reg_if #(
  parameter int unsigned DATA_W = 160,
  parameter int unsigned PC_W   = 32,
  parameter int unsigned EXC_W  = 5,
  parameter int unsigned CNT_W  = 16
);
  logic              we;
  logic              flush;
  logic              req;
  logic [PC_W-1:0]   req_pc;
  logic [PC_W-1:0]   pc_i;
  logic [DATA_W-1:0] data_i;
  logic [EXC_W-1:0]  exc_i;
  logic [EXC_W-1:0]  exc_local_i;
  logic              bd_i;
  logic              valid_i;
  logic [PC_W-1:0]   pc_o;
  logic [DATA_W-1:0] data_o;
  logic [EXC_W-1:0]  exc_o;
  logic              bd_o;
  logic              valid_o;
  logic [CNT_W-1:0]  bubble_cnt_o;

  modport master (
    output we, flush, req, req_pc, pc_i, data_i, exc_i, exc_local_i, bd_i, valid_i,
    input  pc_o, data_o, exc_o, bd_o, valid_o, bubble_cnt_o
  );

  modport slave (
    input  we, flush, req, req_pc, pc_i, data_i, exc_i, exc_local_i, bd_i, valid_i,
    output pc_o, data_o, exc_o, bd_o, valid_o, bubble_cnt_o
  );
endinterface

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (inc && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (clr) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Generic P7 inter-stage register: payload/PC/exception/BD/valid with redirect,
// bubble insertion and a saturating bubble counter.
module pipe_stage_reg
  import pipe_stage_reg_pkg::*;
#(
  parameter int unsigned     DATA_W          = PL_W,
  parameter int unsigned     PC_W            = 32,
  parameter int unsigned     EXC_W           = 5,
  parameter logic [PC_W-1:0] RESET_PC        = RESET_PC_DEF,
  parameter bit              BUBBLE_ON_STALL = 1'b0,
  parameter int unsigned     CNT_W           = 16
) (
  input logic             clk,
  input logic             reset,
  pipe_stage_reg_if.slave bus
);
  stage_act_e        act;
  logic [PC_W-1:0]   pc_d,    pc_q;
  logic [DATA_W-1:0] data_d,  data_q;
  logic [EXC_W-1:0]  exc_d,   exc_q;
  logic              bd_d,    bd_q;
  logic              valid_d, valid_q;
  logic [CNT_W-1:0]  cnt;

  always_comb begin
    act = ACT_HOLD;
    if (bus.req)        act = ACT_REDIRECT;
    else if (bus.flush) act = ACT_BUBBLE;
    else if (!bus.we)   act = BUBBLE_ON_STALL ? ACT_BUBBLE : ACT_HOLD;
    else                act = ACT_LOAD;
  end

  always_comb begin
    pc_d    = pc_q;
    data_d  = data_q;
    exc_d   = exc_q;
    bd_d    = bd_q;
    valid_d = valid_q;
    unique case (act)
      ACT_REDIRECT: begin
        pc_d    = bus.req_pc;
        data_d  = '0;
        exc_d   = '0;
        bd_d    = 1'b0;
        valid_d = 1'b0;
      end
      // A bubble keeps PC/BD so EPC/BD still point at the macroscopic instruction
      ACT_BUBBLE: begin
        pc_d    = bus.pc_i;
        data_d  = '0;
        exc_d   = '0;
        bd_d    = bus.bd_i;
        valid_d = 1'b0;
      end
      ACT_LOAD: begin
        pc_d    = bus.pc_i;
        data_d  = bus.data_i;
        bd_d    = bus.bd_i;
        valid_d = bus.valid_i;
        exc_d   = !bus.valid_i          ? '0 :
                  (bus.exc_i != '0)     ? bus.exc_i : bus.exc_local_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q    <= RESET_PC;
      data_q  <= '0;
      exc_q   <= '0;
      bd_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      data_q  <= data_d;
      exc_q   <= exc_d;
      bd_q    <= bd_d;
      valid_q <= valid_d;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .clr (reset),
    .inc (act == ACT_BUBBLE),
    .cnt (cnt)
  );

  assign bus.pc_o         = pc_q;
  assign bus.data_o       = data_q;
  assign bus.exc_o        = exc_q;
  assign bus.bd_o         = bd_q;
  assign bus.valid_o      = valid_q;
  assign bus.bubble_cnt_o = cnt;
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a hold-on-stall instance and a bubble-on-stall,
// 2-bit-counter instance driven identically and compared with a reference model.
module tb_pipe_stage_reg;
  import pipe_stage_reg_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         r_we, r_flush, r_req, r_bd, r_valid;
  logic [31:0]  r_req_pc, r_pc;
  logic [159:0] r_data;
  logic [4:0]   r_exc, r_exc_local;

  pipe_stage_reg_if #(.DATA_W(160), .CNT_W(16)) if0 ();
  pipe_stage_reg_if #(.DATA_W(32),  .CNT_W(2))  if1 ();

  assign if0.we = r_we;           assign if1.we = r_we;
  assign if0.flush = r_flush;     assign if1.flush = r_flush;
  assign if0.req = r_req;         assign if1.req = r_req;
  assign if0.req_pc = r_req_pc;   assign if1.req_pc = r_req_pc;
  assign if0.pc_i = r_pc;         assign if1.pc_i = r_pc;
  assign if0.data_i = r_data;     assign if1.data_i = r_data[31:0];
  assign if0.exc_i = r_exc;       assign if1.exc_i = r_exc;
  assign if0.exc_local_i = r_exc_local; assign if1.exc_local_i = r_exc_local;
  assign if0.bd_i = r_bd;         assign if1.bd_i = r_bd;
  assign if0.valid_i = r_valid;   assign if1.valid_i = r_valid;

  pipe_stage_reg #(.DATA_W(160), .BUBBLE_ON_STALL(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .bus(if0.slave));
  pipe_stage_reg #(.DATA_W(32),  .BUBBLE_ON_STALL(1'b1), .CNT_W(2))  dut1 (
    .clk(clk), .reset(reset), .bus(if1.slave));

  int checks = 0;
  int failures = 0;

  // Reference state per instance: index 0 = hold-on-stall, 1 = bubble-on-stall
  logic [31:0]  m_pc[2];
  logic [159:0] m_data[2];
  logic [4:0]   m_exc[2];
  logic         m_bd[2], m_valid[2];
  int           m_cnt[2];
  bit           m_bos[2]  = '{1'b0, 1'b1};
  int           m_cmax[2] = '{65535, 3};

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_pc[k] = RESET_PC_DEF; m_data[k] = '0; m_exc[k] = '0;
        m_bd[k] = 0; m_valid[k] = 0; m_cnt[k] = 0;
      end else if (r_req) begin
        m_pc[k] = r_req_pc; m_data[k] = '0; m_exc[k] = '0;
        m_bd[k] = 0; m_valid[k] = 0;
      end else if (r_flush || (!r_we && m_bos[k])) begin
        m_pc[k] = r_pc; m_bd[k] = r_bd; m_data[k] = '0; m_exc[k] = '0;
        m_valid[k] = 0;
        if (m_cnt[k] < m_cmax[k]) m_cnt[k] = m_cnt[k] + 1;
      end else if (r_we) begin
        m_pc[k] = r_pc; m_bd[k] = r_bd; m_valid[k] = r_valid;
        m_data[k] = (k == 0) ? r_data : {128'b0, r_data[31:0]};
        if (!r_valid)          m_exc[k] = '0;
        else if (r_exc != 0)   m_exc[k] = r_exc;
        else                   m_exc[k] = r_exc_local;
      end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc0"},    if0.pc_o,         m_pc[0]);
    chk({tag, ".data0"},  if0.data_o,       m_data[0]);
    chk({tag, ".exc0"},   if0.exc_o,        m_exc[0]);
    chk({tag, ".bd0"},    if0.bd_o,         m_bd[0]);
    chk({tag, ".valid0"}, if0.valid_o,      m_valid[0]);
    chk({tag, ".cnt0"},   if0.bubble_cnt_o, m_cnt[0]);
    chk({tag, ".pc1"},    if1.pc_o,         m_pc[1]);
    chk({tag, ".data1"},  if1.data_o,       m_data[1]);
    chk({tag, ".exc1"},   if1.exc_o,        m_exc[1]);
    chk({tag, ".bd1"},    if1.bd_o,         m_bd[1]);
    chk({tag, ".valid1"}, if1.valid_o,      m_valid[1]);
    chk({tag, ".cnt1"},   if1.bubble_cnt_o, m_cnt[1]);
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    #1;
    model_step();
    check_all(tag);
  endtask

  task automatic idle();
    reset = 0; r_we = 1; r_flush = 0; r_req = 0; r_req_pc = '0; r_pc = '0;
    r_data = '0; r_exc = '0; r_exc_local = '0; r_bd = 0; r_valid = 0;
  endtask

  initial begin
    idle();

    // 1. reset then load
    reset = 1; r_pc = 32'h3004; r_data = 160'hABCD; r_valid = 1;
    cyc("reset");
    chk("reset.pc_const", if0.pc_o, 32'h3000);
    chk("reset.valid_const", if0.valid_o, 1'b0);
    reset = 0;
    cyc("load");
    chk("load.data_const", if0.data_o, 160'hABCD);

    // 2. exception merge
    r_exc = 0; r_exc_local = EXC_OV; r_valid = 1;
    cyc("merge_local");
    chk("merge_local.const", if0.exc_o, 5'd12);
    r_exc = EXC_ADEL;
    cyc("merge_up");
    chk("merge_up.const", if0.exc_o, 5'd4);
    r_valid = 0; r_exc = 0;
    cyc("merge_invalid");
    chk("merge_invalid.const", if0.exc_o, 5'd0);

    // 3. redirect overrides flush and we
    r_req = 1; r_req_pc = HANDLER_PC; r_flush = 1; r_we = 1; r_pc = 32'h3010; r_valid = 1;
    cyc("redirect");
    chk("redirect.pc_const", if0.pc_o, 32'h4180);
    chk("redirect.cnt_const", if0.bubble_cnt_o, 16'd0);
    r_req = 0;

    // 4. bubble keeps PC/BD
    r_pc = 32'h3020; r_bd = 1; r_data = 160'hFFFF;
    cyc("bubble");
    chk("bubble.bd_const", if0.bd_o, 1'b1);
    chk("bubble.cnt_const", if0.bubble_cnt_o, 16'd1);
    r_flush = 0;

    // 5. stall for three cycles after a real load
    r_pc = 32'h3024; r_bd = 0; r_data = 160'h1234; r_valid = 1; r_exc = 0; r_exc_local = 0;
    cyc("preload");
    r_we = 0; r_pc = 32'h3028; r_data = 160'h5555;
    for (int i = 0; i < 3; i++) cyc("stall");
    chk("stall.hold_pc_const", if0.pc_o, 32'h3024);
    chk("stall.cnt0_const", if0.bubble_cnt_o, 16'd1);
    chk("stall.cnt1_sat_const", if1.bubble_cnt_o, 2'd3);
    r_we = 1;

    // 6. saturation on the 2-bit counter, then reset clears it
    reset = 1;
    cyc("sat_reset");
    reset = 0; r_flush = 1;
    for (int i = 0; i < 5; i++) begin
      cyc("sat");
      chk("sat.cnt1_const", if1.bubble_cnt_o, (i < 3) ? i + 1 : 3);
    end
    reset = 1;
    cyc("sat_clear");
    chk("sat_clear.cnt1_const", if1.bubble_cnt_o, 2'd0);

    // reset wins over a simultaneous redirect
    r_req = 1; r_req_pc = 32'h8000_0180;
    cyc("reset_vs_req");
    idle();

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      reset       = ($urandom_range(0, 49) == 0);
      r_req       = ($urandom_range(0, 9) == 0);
      r_flush     = ($urandom_range(0, 4) == 0);
      r_we        = ($urandom_range(0, 9) < 7);
      r_req_pc    = ($urandom_range(0, 1) != 0) ? HANDLER_PC : $urandom;
      r_pc        = $urandom;
      r_data      = {$urandom, $urandom, $urandom, $urandom, $urandom};
      r_exc       = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      r_exc_local = ($urandom_range(0, 2) == 0) ? 5'($urandom) : 5'd0;
      r_bd        = 1'($urandom);
      r_valid     = 1'($urandom);
      cyc("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
